// File: rtl/cacheline_arbiter.sv
// Two-port cacheline arbiter: I$ and D$ share one cache adapter.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention (else D$ wins).
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              d_read,
  input  logic              d_write,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_resp,
  input  logic [LINE_W-1:0] m_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    GAP
  } state_t;

  state_t state, state_nx;
  logic   last_d, last_d_nx;
  logic   rst_q;
  logic   d_req;
  logic   pick_d;
  logic   quiet;

  assign d_req = d_read | d_write;
  // outputs stay zero during reset and the cycle after it
  assign quiet = rst | rst_q;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    last_d_nx = last_d;
    pick_d    = d_req;
    if (i_read && d_req)
      pick_d = RR ? ~last_d : 1'b1;
    case (state)
      IDLE: begin
        if (i_read || d_req) begin
          state_nx  = pick_d ? SERVE_D : SERVE_I;
          last_d_nx = pick_d;
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_resp)
          state_nx = GAP;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    if (!quiet) begin
      case (state)
        SERVE_I: begin
          m_addr = i_addr;
          m_read = i_read;
          i_resp = m_resp;
          if (m_resp)
            i_rdata = m_rdata;
        end
        SERVE_D: begin
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_write = d_write;
          m_read  = d_read & ~d_write;
          d_resp  = m_resp;
          if (m_resp)
            d_rdata = m_rdata;
        end
        default: begin
          m_addr = last_d ? d_addr : i_addr;
          if (last_d)
            m_wdata = d_wdata;
        end
      endcase
    end
  end

endmodule
